// File: rtl/arc_ucode_pkg.sv
// Shared microword field map, COND encodings and sequencer FSM states for the ARC control store.
// Consumed by arc_next_addr and arc_microsequencer (single-step option: USEQ_SINGLE_STEP_EN).
package arc_ucode_pkg;

  localparam int ADDR_W_DEF = 11;
  localparam int WORD_W_DEF = 41;

  localparam int A_MSB     = 40;
  localparam int A_LSB     = 35;
  localparam int AMUX_BIT  = 34;
  localparam int B_MSB     = 33;
  localparam int B_LSB     = 28;
  localparam int BMUX_BIT  = 27;
  localparam int C_MSB     = 26;
  localparam int C_LSB     = 21;
  localparam int CMUX_BIT  = 20;
  localparam int RD_BIT    = 19;
  localparam int WR_BIT    = 18;
  localparam int ALU_MSB   = 17;
  localparam int ALU_LSB   = 14;
  localparam int COND_MSB  = 13;
  localparam int COND_LSB  = 11;
  localparam int JADDR_MSB = 10;
  localparam int JADDR_LSB = 0;

  typedef enum logic [2:0] {
    COND_NEXT   = 3'b000,
    COND_N      = 3'b001,
    COND_Z      = 3'b010,
    COND_V      = 3'b011,
    COND_C      = 3'b100,
    COND_IR13   = 3'b101,
    COND_JUMP   = 3'b110,
    COND_DECODE = 3'b111
  } cond_e;

  typedef enum logic [1:0] {
    ST_RST  = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } state_e;

endpackage

// File: rtl/arc_next_addr.sv
// Combinational next-address selector: picks uPC+1, JADDR or the IR decode address
// from the microword COND field, PSR flags and IR.
module arc_next_addr
  import arc_ucode_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int IR_W   = 32
) (
  input  logic [2:0]        i_cond,
  input  logic [ADDR_W-1:0] i_jaddr,
  input  logic [ADDR_W-1:0] i_upc,
  input  logic              i_flag_n,
  input  logic              i_flag_z,
  input  logic              i_flag_v,
  input  logic              i_flag_c,
  input  logic [IR_W-1:0]   i_ir,
  output logic [ADDR_W-1:0] o_next_addr,
  output logic              o_taken
);

  logic [10:0] w_decode;
  logic        w_ir_unused;

  // Decode entry points live in the upper half of the store, 4 words per opcode.
  assign w_decode    = {1'b1, i_ir[31:30], i_ir[24:19], 2'b00};
  assign w_ir_unused = ^{i_ir[29:25], i_ir[18:0]};

  // NOTE: every always_comb output is assigned a default first so no path leaves it unassigned (no latch).
  always_comb begin
    o_taken     = 1'b0;
    o_next_addr = i_upc + ADDR_W'(1);
    case (cond_e'(i_cond))
      COND_N:      o_taken = i_flag_n;
      COND_Z:      o_taken = i_flag_z;
      COND_V:      o_taken = i_flag_v;
      COND_C:      o_taken = i_flag_c;
      COND_IR13:   o_taken = i_ir[13];
      COND_JUMP:   o_taken = 1'b1;
      COND_DECODE: o_taken = 1'b1;
      default:     o_taken = 1'b0;
    endcase
    if (o_taken) begin
      o_next_addr = (cond_e'(i_cond) == COND_DECODE) ? ADDR_W'(w_decode) : i_jaddr;
    end
  end

endmodule

// File: rtl/arc_microsequencer.sv
// ARC control-store sequencer: owns the uPC, stalls on memory RD/WR until MEM_ACK, strobes ADVANCE.
// Optional single-step mode (STEP input, HOLD state) is enabled by defining USEQ_SINGLE_STEP_EN.
module arc_microsequencer
  import arc_ucode_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int WORD_W = WORD_W_DEF,
  parameter int IR_W   = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  output logic [ADDR_W-1:0] ROM_ADDR,
  input  logic [WORD_W-1:0] ROM_DATA,
  input  logic [IR_W-1:0]   IR,
  input  logic              FLAG_N,
  input  logic              FLAG_Z,
  input  logic              FLAG_V,
  input  logic              FLAG_C,
  input  logic              MEM_ACK,
`ifdef USEQ_SINGLE_STEP_EN
  input  logic              STEP,
`endif
  output logic              MEM_RD,
  output logic              MEM_WR,
  output logic              ADVANCE,
  output logic              BRANCH_TAKEN,
  output logic [1:0]        STATE
);

  state_e            r_state;
  state_e            w_state_nxt;
  state_e            w_after_adv;
  logic [ADDR_W-1:0] r_upc;
  logic [ADDR_W-1:0] w_upc_nxt;
  logic [ADDR_W-1:0] w_next_addr;
  logic              w_taken;
  logic              w_advance;
  logic              w_rd;
  logic              w_wr;
  logic              w_word_unused;

  assign w_rd          = ROM_DATA[RD_BIT];
  assign w_wr          = ROM_DATA[WR_BIT];
  assign w_word_unused = ^{ROM_DATA[A_MSB:CMUX_BIT], ROM_DATA[ALU_MSB:ALU_LSB]};

`ifdef USEQ_SINGLE_STEP_EN
  assign w_after_adv = ST_HOLD;
`else
  assign w_after_adv = ST_RUN;
`endif

  arc_next_addr #(.ADDR_W(ADDR_W), .IR_W(IR_W)) u_next_addr (
    .i_cond      (ROM_DATA[COND_MSB:COND_LSB]),
    .i_jaddr     (ADDR_W'(ROM_DATA[JADDR_MSB:JADDR_LSB])),
    .i_upc       (r_upc),
    .i_flag_n    (FLAG_N),
    .i_flag_z    (FLAG_Z),
    .i_flag_v    (FLAG_V),
    .i_flag_c    (FLAG_C),
    .i_ir        (IR),
    .o_next_addr (w_next_addr),
    .o_taken     (w_taken)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_upc_nxt   = r_upc;
    w_advance   = 1'b0;
    case (r_state)
      ST_RST: begin
        w_upc_nxt   = '0;
`ifdef USEQ_SINGLE_STEP_EN
        w_state_nxt = ST_HOLD;
`else
        w_state_nxt = ST_RUN;
`endif
      end
      ST_RUN: begin
        if (!(w_rd || w_wr) || MEM_ACK) begin
          w_advance   = 1'b1;
          w_upc_nxt   = w_next_addr;
          w_state_nxt = w_after_adv;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (MEM_ACK) begin
          w_advance   = 1'b1;
          w_upc_nxt   = w_next_addr;
          w_state_nxt = w_after_adv;
        end
      end
`ifdef USEQ_SINGLE_STEP_EN
      ST_HOLD: begin
        if (STEP) w_state_nxt = ST_RUN;
      end
`endif
      default: w_state_nxt = ST_RST;
    endcase
    // Reset suppresses the commit strobe even if the memory acks in the same cycle.
    if (RESET) w_advance = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= ST_RST;
      r_upc   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_upc   <= w_upc_nxt;
    end
  end

  assign ROM_ADDR     = r_upc;
  assign MEM_RD       = w_rd && (r_state != ST_RST);
  assign MEM_WR       = w_wr && (r_state != ST_RST);
  assign ADVANCE      = w_advance;
  assign BRANCH_TAKEN = w_advance && w_taken;
  assign STATE        = r_state;

endmodule

// File: tb/tb_arc_microsequencer.sv
// Directed self-checking bench for arc_microsequencer; the control store is a bench-side array.
module tb_arc_microsequencer;
  import arc_ucode_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [10:0] ROM_ADDR;
  logic [40:0] ROM_DATA;
  logic [31:0] IR = '0;
  logic        FLAG_N = 1'b0, FLAG_Z = 1'b0, FLAG_V = 1'b0, FLAG_C = 1'b0;
  logic        MEM_ACK = 1'b0;
`ifdef USEQ_SINGLE_STEP_EN
  logic        STEP = 1'b0;
`endif
  logic        MEM_RD, MEM_WR, ADVANCE, BRANCH_TAKEN;
  logic [1:0]  STATE;

  logic [40:0] rom [0:2047];
  int checks = 0;
  int failures = 0;

  assign ROM_DATA = rom[ROM_ADDR];

  always #5 CLK = ~CLK;

  arc_microsequencer dut (
    .CLK(CLK), .RESET(RESET), .ROM_ADDR(ROM_ADDR), .ROM_DATA(ROM_DATA), .IR(IR),
    .FLAG_N(FLAG_N), .FLAG_Z(FLAG_Z), .FLAG_V(FLAG_V), .FLAG_C(FLAG_C), .MEM_ACK(MEM_ACK),
`ifdef USEQ_SINGLE_STEP_EN
    .STEP(STEP),
`endif
    .MEM_RD(MEM_RD), .MEM_WR(MEM_WR), .ADVANCE(ADVANCE), .BRANCH_TAKEN(BRANCH_TAKEN), .STATE(STATE)
  );

  function automatic logic [40:0] mk(input logic rd, input logic wr, input logic [2:0] cond,
                                     input logic [10:0] ja);
    logic [40:0] w;
    w = '0;
    w[RD_BIT] = rd;
    w[WR_BIT] = wr;
    w[COND_MSB:COND_LSB] = cond;
    w[JADDR_MSB:JADDR_LSB] = ja;
    return w;
  endfunction

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset;
    RESET = 1'b1;
    MEM_ACK = 1'b0;
    tick();
    tick();
    RESET = 1'b0;
    #1;
  endtask

  // Reset, then jump from word 0 straight to target; returns with uPC == target in RUN.
  task automatic goto(input logic [10:0] target);
    rom[0] = mk(1'b0, 1'b0, COND_JUMP, target);
    do_reset();
    tick();
    tick();
  endtask

  task automatic test_reset;
    rom[0] = mk(1'b0, 1'b0, COND_NEXT, 11'd0);
    rom[1] = mk(1'b0, 1'b0, COND_NEXT, 11'd0);
    do_reset();
    checks++; if (STATE !== 2'd0) begin failures++; $display("FAIL rst_state: got %0d exp 0", STATE); end
    checks++; if (ROM_ADDR !== 11'd0) begin failures++; $display("FAIL rst_addr: got %0d exp 0", ROM_ADDR); end
    checks++; if (ADVANCE !== 1'b0) begin failures++; $display("FAIL rst_adv: got %0b exp 0", ADVANCE); end
    checks++; if (MEM_RD !== 1'b0 || MEM_WR !== 1'b0 || BRANCH_TAKEN !== 1'b0) begin failures++; $display("FAIL rst_outs: got rd=%0b wr=%0b br=%0b exp 0", MEM_RD, MEM_WR, BRANCH_TAKEN); end
    tick();
    checks++; if (ROM_ADDR !== 11'd0) begin failures++; $display("FAIL run0_addr: got %0d exp 0", ROM_ADDR); end
    checks++; if (STATE !== 2'd1) begin failures++; $display("FAIL run0_state: got %0d exp 1", STATE); end
    checks++; if (ADVANCE !== 1'b1) begin failures++; $display("FAIL run0_adv: got %0b exp 1", ADVANCE); end
    tick();
    checks++; if (ROM_ADDR !== 11'd1) begin failures++; $display("FAIL run1_addr: got %0d exp 1", ROM_ADDR); end
  endtask

  task automatic test_decode_ir13;
    rom[0] = mk(1'b0, 1'b0, COND_DECODE, 11'd0);
    rom[1600] = mk(1'b0, 1'b0, COND_IR13, 11'd1602);
    IR = 32'h8080_0000;
    do_reset();
    tick();
    checks++; if (BRANCH_TAKEN !== 1'b1) begin failures++; $display("FAIL dec_taken: got %0b exp 1", BRANCH_TAKEN); end
    tick();
    checks++; if (ROM_ADDR !== 11'd1600) begin failures++; $display("FAIL dec_addr: got %0d exp 1600", ROM_ADDR); end
    IR = 32'h8080_2000;
    #1;
    checks++; if (BRANCH_TAKEN !== 1'b1) begin failures++; $display("FAIL ir13_taken: got %0b exp 1", BRANCH_TAKEN); end
    tick();
    checks++; if (ROM_ADDR !== 11'd1602) begin failures++; $display("FAIL ir13_addr: got %0d exp 1602", ROM_ADDR); end
    IR = 32'h8080_0000;
    goto(11'd1600);
    checks++; if (BRANCH_TAKEN !== 1'b0) begin failures++; $display("FAIL ir13n_taken: got %0b exp 0", BRANCH_TAKEN); end
    tick();
    checks++; if (ROM_ADDR !== 11'd1601) begin failures++; $display("FAIL ir13n_addr: got %0d exp 1601", ROM_ADDR); end
  endtask

  task automatic test_flags;
    logic [3:0] f;
    rom[10] = mk(1'b0, 1'b0, COND_Z, 11'd12);
    rom[20] = mk(1'b0, 1'b0, COND_JUMP, 11'd2);
    {FLAG_N, FLAG_Z, FLAG_V, FLAG_C} = 4'b0000;
    goto(11'd10);
    tick();
    checks++; if (ROM_ADDR !== 11'd11) begin failures++; $display("FAIL z0_addr: got %0d exp 11", ROM_ADDR); end
    FLAG_Z = 1'b1;
    goto(11'd10);
    checks++; if (BRANCH_TAKEN !== 1'b1) begin failures++; $display("FAIL z1_taken: got %0b exp 1", BRANCH_TAKEN); end
    tick();
    checks++; if (ROM_ADDR !== 11'd12) begin failures++; $display("FAIL z1_addr: got %0d exp 12", ROM_ADDR); end
    for (int k = 0; k < 2; k++) begin
      {FLAG_N, FLAG_Z, FLAG_V, FLAG_C} = (k == 0) ? 4'b0000 : 4'b1111;
      goto(11'd20);
      tick();
      checks++; if (ROM_ADDR !== 11'd2) begin failures++; $display("FAIL jump_addr[%0d]: got %0d exp 2", k, ROM_ADDR); end
    end
    // Each flag condition: only its own flag set -> taken; all others set -> not taken.
    for (int i = 0; i < 4; i++) begin
      for (int t = 0; t < 2; t++) begin
        rom[30] = mk(1'b0, 1'b0, 3'(i + 1), 11'd40);
        f = 4'b1000 >> i;
        if (t == 0) f = ~f;
        {FLAG_N, FLAG_Z, FLAG_V, FLAG_C} = f;
        goto(11'd30);
        checks++; if (BRANCH_TAKEN !== 1'(t)) begin failures++; $display("FAIL flag_taken[c%0d t%0d]: got %0b exp %0d", i + 1, t, BRANCH_TAKEN, t); end
        tick();
        checks++; if (ROM_ADDR !== ((t == 1) ? 11'd40 : 11'd31)) begin failures++; $display("FAIL flag_addr[c%0d t%0d]: got %0d exp %0d", i + 1, t, ROM_ADDR, (t == 1) ? 40 : 31); end
      end
    end
    {FLAG_N, FLAG_Z, FLAG_V, FLAG_C} = 4'b0000;
  endtask

  task automatic test_mem_stall;
    rom[5] = mk(1'b1, 1'b0, COND_Z, 11'd9);
    FLAG_Z = 1'b0;
    goto(11'd5);
    MEM_ACK = 1'b0;
    #1;
    checks++; if (STATE !== 2'd1 || ROM_ADDR !== 11'd5 || MEM_RD !== 1'b1 || ADVANCE !== 1'b0) begin failures++; $display("FAIL stall_c0: got st=%0d a=%0d rd=%0b adv=%0b exp 1/5/1/0", STATE, ROM_ADDR, MEM_RD, ADVANCE); end
    for (int c = 1; c < 3; c++) begin
      tick();
      FLAG_Z = 1'b1;
      #1;
      checks++; if (STATE !== 2'd2 || ROM_ADDR !== 11'd5 || MEM_RD !== 1'b1 || ADVANCE !== 1'b0) begin failures++; $display("FAIL stall_c%0d: got st=%0d a=%0d rd=%0b adv=%0b exp 2/5/1/0", c, STATE, ROM_ADDR, MEM_RD, ADVANCE); end
    end
    tick();
    FLAG_Z = 1'b0;
    MEM_ACK = 1'b1;
    #1;
    checks++; if (STATE !== 2'd2 || ROM_ADDR !== 11'd5 || ADVANCE !== 1'b1 || BRANCH_TAKEN !== 1'b0) begin failures++; $display("FAIL stall_ack: got st=%0d a=%0d adv=%0b br=%0b exp 2/5/1/0", STATE, ROM_ADDR, ADVANCE, BRANCH_TAKEN); end
    tick();
    MEM_ACK = 1'b0;
    #1;
    checks++; if (ROM_ADDR !== 11'd6 || STATE !== 2'd1) begin failures++; $display("FAIL stall_after: got a=%0d st=%0d exp 6/1", ROM_ADDR, STATE); end

    goto(11'd5);
    tick();
    checks++; if (STATE !== 2'd2) begin failures++; $display("FAIL rstwait_pre: got %0d exp 2", STATE); end
    RESET = 1'b1;
    MEM_ACK = 1'b1;
    #1;
    checks++; if (ADVANCE !== 1'b0 || BRANCH_TAKEN !== 1'b0) begin failures++; $display("FAIL rstwait_adv: got adv=%0b br=%0b exp 0/0", ADVANCE, BRANCH_TAKEN); end
    tick();
    RESET = 1'b0;
    MEM_ACK = 1'b0;
    #1;
    checks++; if (ROM_ADDR !== 11'd0 || STATE !== 2'd0) begin failures++; $display("FAIL rstwait_post: got a=%0d st=%0d exp 0/0", ROM_ADDR, STATE); end

    rom[7] = mk(1'b0, 1'b1, COND_NEXT, 11'd0);
    goto(11'd7);
    MEM_ACK = 1'b1;
    #1;
    checks++; if (MEM_WR !== 1'b1 || MEM_RD !== 1'b0 || ADVANCE !== 1'b1 || STATE !== 2'd1) begin failures++; $display("FAIL wr_ack: got wr=%0b rd=%0b adv=%0b st=%0d exp 1/0/1/1", MEM_WR, MEM_RD, ADVANCE, STATE); end
    tick();
    MEM_ACK = 1'b0;
    #1;
    checks++; if (ROM_ADDR !== 11'd8) begin failures++; $display("FAIL wr_addr: got %0d exp 8", ROM_ADDR); end
  endtask

  task automatic test_wrap;
    rom[2047] = mk(1'b0, 1'b0, COND_NEXT, 11'd0);
    goto(11'd2047);
    checks++; if (ROM_ADDR !== 11'd2047) begin failures++; $display("FAIL wrap_pre: got %0d exp 2047", ROM_ADDR); end
    tick();
    checks++; if (ROM_ADDR !== 11'd0 || STATE !== 2'd1) begin failures++; $display("FAIL wrap_addr: got a=%0d st=%0d exp 0/1", ROM_ADDR, STATE); end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) rom[i] = '0;
    test_reset();
    test_decode_ir13();
    test_flags();
    test_mem_stall();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
